// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: op codes and FSM states shared by the load/store unit files.
package mips_lsu_pkg;
    typedef enum logic [3:0] {
        LB  = 4'd0,
        LBU = 4'd1,
        LH  = 4'd2,
        LHU = 4'd3,
        LW  = 4'd4,
        LWL = 4'd5,
        LWR = 4'd6,
        SB  = 4'd8,
        SH  = 4'd9,
        SW  = 4'd10,
        SWL = 4'd11,
        SWR = 4'd12
    } lsu_op_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} lsu_state_t;
endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: lane/data shaping for stores, load extension/merge, alignment check.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  ofs,
    input  logic [31:0] rt_val,
    input  logic [31:0] mem_data,
    output logic [3:0]  byteenable,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        word_addr,
    output logic        err
);
    logic [4:0] sh;
    logic [4:0] shl;
    assign sh  = {ofs, 3'b000};
    assign shl = {~ofs, 3'b000};
    // LWL/SWL/LWR/SWR issue a word address, so lanes and data are positioned here, not by the bridge
    always_comb begin
        byteenable = 4'b1111;
        write_data = rt_val;
        load_data  = mem_data;
        word_addr  = 1'b0;
        err        = 1'b0;
        case (op)
            LB:  begin byteenable = 4'b0001; load_data = {{24{mem_data[7]}}, mem_data[7:0]}; end
            LBU: begin byteenable = 4'b0001; load_data = {24'd0, mem_data[7:0]}; end
            LH:  begin byteenable = 4'b0011; err = ofs[0]; load_data = {{16{mem_data[15]}}, mem_data[15:0]}; end
            LHU: begin byteenable = 4'b0011; err = ofs[0]; load_data = {16'd0, mem_data[15:0]}; end
            LW:  err = |ofs;
            LWL: begin
                word_addr = 1'b1;
                load_data = (mem_data << shl) | (rt_val & ~(32'hFFFF_FFFF << shl));
            end
            LWR: begin
                word_addr = 1'b1;
                load_data = (mem_data >> sh) | (rt_val & ~(32'hFFFF_FFFF >> sh));
            end
            SB:  byteenable = 4'b0001;
            SH:  begin byteenable = 4'b0011; err = ofs[0]; end
            SW:  err = |ofs;
            SWL: begin word_addr = 1'b1; byteenable = 4'b1111 >> ~ofs; write_data = rt_val >> shl; end
            SWR: begin word_addr = 1'b1; byteenable = 4'b1111 << ofs; write_data = rt_val << sh; end
            default: err = 1'b1;
        endcase
    end
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: load/store unit FSM between execute and the byte-enable Avalon bridge.
module mips_lsu
    import mips_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  lsu_op_t     op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_val,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data,
    input  logic        mem_busy
);
    lsu_state_t  state, nxt;
    lsu_op_t     op_q, cur_op;
    logic [1:0]  ofs_q, cur_ofs;
    logic [31:0] rt_q, cur_rt;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    logic        word_addr, err, start, resp_bus;
    logic        done_d, addr_err_d, rd_d, wr_d, load_cap;

    assign ready   = state == IDLE;
    assign start   = ready && req;
    assign cur_op  = ready ? op : op_q;
    assign cur_ofs = ready ? addr[1:0] : ofs_q;
    assign cur_rt  = ready ? rt_val : rt_q;
    assign resp_bus = state == WAIT && !mem_busy;

    mips_lsu_align u_align (
        .op         (cur_op),
        .ofs        (cur_ofs),
        .rt_val     (cur_rt),
        .mem_data   (mem_read_data),
        .byteenable (be),
        .write_data (wd),
        .load_data  (ld),
        .word_addr  (word_addr),
        .err        (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= LB;
            ofs_q          <= 2'd0;
            rt_q           <= 32'd0;
            done           <= 1'b0;
            addr_err       <= 1'b0;
            rdata          <= 32'd0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            mem_byteenable <= 4'b0000;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            state     <= nxt;
            done      <= done_d;
            addr_err  <= addr_err_d;
            mem_read  <= rd_d;
            mem_write <= wr_d;
            if (start) begin
                op_q  <= op;
                ofs_q <= addr[1:0];
                rt_q  <= rt_val;
            end
            // bus fields stay frozen through WAIT: the bridge shifts read data by the live address
            if (start && !err) begin
                mem_address    <= word_addr ? {addr[31:2], 2'b00} : addr;
                mem_byteenable <= be;
                mem_write_data <= wd;
            end
            if (load_cap) rdata <= ld;
        end
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = req ? (err ? RESP : ISSUE) : IDLE;
            ISSUE:   nxt = WAIT;
            WAIT:    nxt = mem_busy ? WAIT : RESP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        done_d     = (start && err) || resp_bus;
        addr_err_d = start && err;
        rd_d       = start && !err && !cur_op[3];
        wr_d       = start && !err && cur_op[3];
        load_cap   = resp_bus && !op_q[3];
    end
endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: directed checks of mips_lsu against a byte-enable bridge/memory model.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    lsu_op_t     op;
    logic [31:0] addr = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        ready, done, addr_err, mem_read, mem_write, mem_busy;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic [3:0]  mem_byteenable;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mips_lsu dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .op             (op),
        .addr           (addr),
        .rt_val         (rt_val),
        .ready          (ready),
        .done           (done),
        .rdata          (rdata),
        .addr_err       (addr_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_byteenable (mem_byteenable),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data),
        .mem_busy       (mem_busy)
    );

    // bridge model: shifts lanes/data by address[1:0], waitrequest for wait_n cycles
    logic [31:0] mem [0:255];
    logic [31:0] rd_q = 32'd0;
    int          cnt = 0;
    int          wait_n = 0;
    assign mem_read_data = rd_q;
    assign mem_busy = cnt != 0;

    always @(posedge clk) begin
        logic [3:0]  sbe;
        logic [31:0] swd;
        logic [31:0] lanes;
        if (rst) cnt <= 0;
        else if (mem_read || mem_write) begin
            cnt <= wait_n;
            lanes = {{8{mem_byteenable[3]}}, {8{mem_byteenable[2]}}, {8{mem_byteenable[1]}}, {8{mem_byteenable[0]}}};
            if (mem_read) rd_q <= (mem[mem_address[9:2]] >> (8 * mem_address[1:0])) & lanes;
            if (mem_write) begin
                sbe = mem_byteenable << mem_address[1:0];
                swd = mem_write_data << (8 * mem_address[1:0]);
                for (int i = 0; i < 4; i++)
                    if (sbe[i]) mem[mem_address[9:2]][8*i +: 8] <= swd[8*i +: 8];
            end
        end else if (cnt != 0) cnt <= cnt - 1;
    end

    int          lat, rd_cycles, wr_cycles;
    logic        both, unstable;
    logic [31:0] s_addr, s_wd, d_rdata;
    logic [3:0]  s_be;
    logic        d_err;

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r, input int poke_at);
        int guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready=%b required 1", ready);
        end
        req = 1'b1;
        op = lsu_op_t'(o);
        addr = a;
        rt_val = r;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0; rd_cycles = 0; wr_cycles = 0; both = 1'b0; unstable = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_read || mem_write) begin
                rd_cycles += int'(mem_read);
                wr_cycles += int'(mem_write);
                s_addr = mem_address; s_be = mem_byteenable; s_wd = mem_write_data;
            end else if (rd_cycles + wr_cycles > 0 && !done && (mem_address !== s_addr || mem_byteenable !== s_be))
                unstable = 1'b1;
            if (mem_read && mem_write) both = 1'b1;
            if (lat == poke_at) begin
                req = 1'b1; op = LB; addr = 32'h200;
            end else req = 1'b0;
            if (done) break;
        end
        req = 1'b0;
        d_err = addr_err;
        d_rdata = rdata;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if ({done, addr_err, mem_read, mem_write} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {done, addr_err, mem_read, mem_write}); end
        n_cmp++; if ({rdata, mem_address, mem_write_data, mem_byteenable} !== 100'd0) begin n_bad++; $display("FAIL reset_data: rdata=%h addr=%h wd=%h be=%b want all 0", rdata, mem_address, mem_write_data, mem_byteenable); end
        rst = 1'b0;
    endtask

    task automatic test_loads;
        logic [3:0]  t_op [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [31:0] t_a  [7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h102};
        logic [31:0] t_rt [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h11223344, 32'h11223344};
        logic [31:0] t_ma [7] = '{32'h102, 32'h102, 32'h102, 32'h100, 32'h100, 32'h100, 32'h100};
        logic [3:0]  t_be [7] = '{4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b1111, 4'b1111, 4'b1111};
        logic [31:0] t_r  [7] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB, 32'hAABB3344, 32'h11228899};
        for (int i = 0; i < 7; i++) begin
            do_op(t_op[i], t_a[i], t_rt[i], 0);
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL load%0d_latency: got %0d want 3", i, lat); end
            n_cmp++; if (d_rdata !== t_r[i]) begin n_bad++; $display("FAIL load%0d_rdata: got %h want %h", i, d_rdata, t_r[i]); end
            n_cmp++; if (s_addr !== t_ma[i] || s_be !== t_be[i]) begin n_bad++; $display("FAIL load%0d_bus: addr=%h be=%b want %h %b", i, s_addr, s_be, t_ma[i], t_be[i]); end
            n_cmp++; if (rd_cycles !== 1 || wr_cycles !== 0 || d_err !== 1'b0) begin n_bad++; $display("FAIL load%0d_sel: rd=%0d wr=%0d err=%b want 1 0 0", i, rd_cycles, wr_cycles, d_err); end
        end
    endtask

    task automatic test_stores;
        mem[8'h40] = 32'h8899AABB;
        do_op(4'd12, 32'h101, 32'h11223344, 0);
        n_cmp++; if (s_be !== 4'b1110 || s_wd !== 32'h22334400 || s_addr !== 32'h100) begin n_bad++; $display("FAIL swr_bus: be=%b wd=%h addr=%h want 1110 22334400 00000100", s_be, s_wd, s_addr); end
        n_cmp++; if (lat !== 3 || wr_cycles !== 1 || rd_cycles !== 0) begin n_bad++; $display("FAIL swr_timing: lat=%0d wr=%0d rd=%0d want 3 1 0", lat, wr_cycles, rd_cycles); end
        n_cmp++; if (d_rdata !== 32'h11228899) begin n_bad++; $display("FAIL swr_rdata_held: got %h want 11228899", d_rdata); end
        n_cmp++; if (mem[8'h40] !== 32'h223344BB) begin n_bad++; $display("FAIL swr_word: got %h want 223344BB", mem[8'h40]); end
        mem[8'h40] = 32'h8899AABB;
        do_op(4'd11, 32'h101, 32'h11223344, 0);
        n_cmp++; if (s_be !== 4'b0011 || s_wd !== 32'h00001122 || s_addr !== 32'h100) begin n_bad++; $display("FAIL swl_bus: be=%b wd=%h addr=%h want 0011 00001122 00000100", s_be, s_wd, s_addr); end
        n_cmp++; if (mem[8'h40] !== 32'h88991122) begin n_bad++; $display("FAIL swl_word: got %h want 88991122", mem[8'h40]); end
        do_op(4'd8, 32'h103, 32'h00000077, 0);
        n_cmp++; if (s_be !== 4'b0001 || s_addr !== 32'h103 || mem[8'h40] !== 32'h77991122) begin n_bad++; $display("FAIL sb: be=%b addr=%h word=%h want 0001 00000103 77991122", s_be, s_addr, mem[8'h40]); end
        do_op(4'd4, 32'h100, 32'h0, 0);
        n_cmp++; if (d_rdata !== 32'h77991122) begin n_bad++; $display("FAIL lw_after_stores: got %h want 77991122", d_rdata); end
    endtask

    task automatic test_errors;
        logic [3:0]  e_op [4] = '{4'd9, 4'd4, 4'd7, 4'd13};
        logic [31:0] e_a  [4] = '{32'h101, 32'h102, 32'h100, 32'h100};
        for (int i = 0; i < 4; i++) begin
            do_op(e_op[i], e_a[i], 32'hDEADBEEF, 0);
            n_cmp++; if (lat !== 1 || d_err !== 1'b1) begin n_bad++; $display("FAIL err%0d_done: lat=%0d addr_err=%b want 1 1", i, lat, d_err); end
            n_cmp++; if (rd_cycles !== 0 || wr_cycles !== 0 || d_rdata !== 32'h77991122) begin n_bad++; $display("FAIL err%0d_side: rd=%0d wr=%0d rdata=%h want 0 0 77991122", i, rd_cycles, wr_cycles, d_rdata); end
        end
        @(negedge clk);
        n_cmp++; if (addr_err !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL err_pulse: addr_err=%b done=%b want 0 0", addr_err, done); end
    endtask

    task automatic test_wait;
        mem[8'h40] = 32'h8899AABB;
        wait_n = 3;
        do_op(4'd4, 32'h100, 32'h0, 3);
        wait_n = 0;
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL wait_latency: got %0d want 6", lat); end
        n_cmp++; if (d_rdata !== 32'h8899AABB || unstable !== 1'b0 || both !== 1'b0) begin n_bad++; $display("FAIL wait_data: rdata=%h unstable=%b both=%b want 8899AABB 0 0", d_rdata, unstable, both); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 1'b1 || mem_read !== 1'b0) begin n_bad++; $display("FAIL wait_poke_ignored%0d: ready=%b mem_read=%b want 1 0", i, ready, mem_read); end
        end
    endtask

    task automatic test_back_to_back;
        do_op(4'd0, 32'h102, 32'h0, 0);
        n_cmp++; if (d_rdata !== 32'hFFFFFF99) begin n_bad++; $display("FAIL b2b_first: got %h want FFFFFF99", d_rdata); end
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready: got %b want 1", ready); end
        do_op(4'd3, 32'h100, 32'h0, 0);
        n_cmp++; if (lat !== 3 || d_rdata !== 32'h0000AABB) begin n_bad++; $display("FAIL b2b_second: lat=%0d rdata=%h want 3 0000AABB", lat, d_rdata); end
    endtask

    task automatic test_reset_mid;
        wait_n = 5;
        @(negedge clk);
        req = 1'b1; op = LW; addr = 32'h100; rt_val = 32'h0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0 || mem_address !== 32'h100) begin n_bad++; $display("FAIL mid_wait_state: ready=%b addr=%h want 0 00000100", ready, mem_address); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_n = 0;
        n_cmp++; if (ready !== 1'b1 || {done, addr_err, mem_read, mem_write} !== 4'b0) begin n_bad++; $display("FAIL mid_rst_flags: ready=%b flags=%b want 1 0000", ready, {done, addr_err, mem_read, mem_write}); end
        n_cmp++; if ({rdata, mem_address, mem_write_data, mem_byteenable} !== 100'd0) begin n_bad++; $display("FAIL mid_rst_data: rdata=%h addr=%h wd=%h be=%b want all 0", rdata, mem_address, mem_write_data, mem_byteenable); end
    endtask

    initial begin
        op = LB;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'h8899AABB;
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_wait();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
